// File: rtl/run_stats_pkg.sv
// run_stats_pkg: shared types and defaults for the run-statistics collector.
//   run_state_e   : collector FSM encoding (IDLE / LO / HI), also driven out on RUN_STATE
//   MIN_RUN_DFLT  : run length that the detector's first terminal-state cycle represents
package run_stats_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } run_state_e;

    localparam int MIN_RUN_DFLT = 4;

endpackage

// File: rtl/run_stats_sat_counter.sv
// sat_counter: W-bit saturating counter with async reset, sync clear and sync load.
//   clk_i, rst_i (async, active-high), clr_i (sync clear, highest priority),
//   load_i/load_val_i (sync load, beats increment), inc_i (increment, sticks at all-ones)
//   count_o : registered count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i)
            count_d = '0;
        else if (load_i)
            count_d = load_val_i;
        else if (inc_i && (count_q != {W{1'b1}}))
            count_d = count_q + W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/run_stats.sv
// run_stats: per-polarity run statistics behind the serial run detector.
//   CLK, RESET (async, active-high), CLR (sync clear of everything)
//   RUN_LO / RUN_HI : detector terminal states (long run of 0s / 1s)
//   ZERO_RUNS / ONE_RUNS : saturating run-start counts
//   CUR_LEN : length of run in progress (0 when idle), saturating
//   MAX_LEN : longest finished run
//   NEW_RUN : one-cycle pulse on each run start
//   RUN_STATE : FSM state, ERR : sticky "both inputs high" flag
module run_stats
    import run_stats_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int LEN_W   = 8,
    parameter int MIN_RUN = MIN_RUN_DFLT
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             RUN_LO,
    input  logic             RUN_HI,
    input  logic             CLR,
    output logic [CNT_W-1:0] ZERO_RUNS,
    output logic [CNT_W-1:0] ONE_RUNS,
    output logic [LEN_W-1:0] CUR_LEN,
    output logic [LEN_W-1:0] MAX_LEN,
    output logic             NEW_RUN,
    output logic [1:0]       RUN_STATE,
    output logic             ERR
);

    run_state_e       state_q;
    logic [LEN_W-1:0] max_len_q;
    logic             new_run_q, err_q;

    // Event decode; both-high is a protocol error that freezes all statistics.
    logic act, both, start_lo, start_hi, cont, end_run, go_idle;
    assign both     = RUN_LO & RUN_HI;
    assign act      = !CLR && !both;
    assign start_lo = act && RUN_LO && (state_q != ST_LO);
    assign start_hi = act && RUN_HI && (state_q != ST_HI);
    assign cont     = act && ((state_q == ST_LO && RUN_LO) || (state_q == ST_HI && RUN_HI));
    // Any non-continuing edge out of LO/HI finishes the run: either a gap or a polarity switch.
    assign end_run  = act && (state_q != ST_IDLE) && !cont;
    assign go_idle  = end_run && !RUN_LO && !RUN_HI;

    sat_counter #(.W(CNT_W)) u_zero_runs (
        .clk_i(CLK), .rst_i(RESET), .clr_i(CLR),
        .inc_i(start_lo), .load_i(1'b0), .load_val_i('0), .count_o(ZERO_RUNS)
    );

    sat_counter #(.W(CNT_W)) u_one_runs (
        .clk_i(CLK), .rst_i(RESET), .clr_i(CLR),
        .inc_i(start_hi), .load_i(1'b0), .load_val_i('0), .count_o(ONE_RUNS)
    );

    // A start loads MIN_RUN; a gap loads 0; a continuation increments.
    sat_counter #(.W(LEN_W)) u_cur_len (
        .clk_i(CLK), .rst_i(RESET), .clr_i(CLR),
        .inc_i(cont), .load_i(start_lo || start_hi || go_idle),
        .load_val_i(go_idle ? '0 : LEN_W'(MIN_RUN)), .count_o(CUR_LEN)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            max_len_q <= '0;
            new_run_q <= 1'b0;
            err_q     <= 1'b0;
        end else if (CLR) begin
            state_q   <= ST_IDLE;
            max_len_q <= '0;
            new_run_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            new_run_q <= start_lo || start_hi;
            if (both) err_q <= 1'b1;
            if (end_run && (CUR_LEN > max_len_q)) max_len_q <= CUR_LEN;
            if (start_lo)     state_q <= ST_LO;
            else if (start_hi) state_q <= ST_HI;
            else if (go_idle)  state_q <= ST_IDLE;
        end
    end

    assign MAX_LEN   = max_len_q;
    assign NEW_RUN   = new_run_q;
    assign RUN_STATE = state_q;
    assign ERR       = err_q;

endmodule
